// File: rtl/pe_array_param.sv
// rtl/pe_array_param.sv - weight-stationary systolic PE array with windowed accumulation and quantized output
module pe_array_param #(
  parameter int ROWS = 8,
  parameter int COLS = 4,
  parameter int DW   = 7,
  parameter int WW   = 7,
  parameter int AW   = 20,
  parameter int OW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_load,
  input  logic [ROWS*WW-1:0]      w_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [COLS*DW-1:0]      in_data,
  output logic                    in_ready,
  input  logic                    relu_en,
  input  logic [4:0]              shift_amt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ROWS*COLS*OW-1:0] out_data,
  output logic                    busy
);

  // Product width: unsigned data gains a sign bit, then full signed product.
  localparam int PW = WW + DW + 1;
  localparam logic signed [AW-1:0] QMAX = AW'((1 << (OW - 1)) - 1);
  localparam logic signed [AW-1:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                  state_q, state_d;
  logic signed [WW-1:0]    w_q [ROWS];
  logic signed [AW-1:0]    acc_q [ROWS][COLS];
  logic signed [AW-1:0]    acc_d [ROWS][COLS];
  // pipe_*_q[r] holds what row r worked on in the previous cycle; it feeds row r+1.
  logic [COLS*DW-1:0]      pipe_data_q [ROWS];
  logic [ROWS-1:0]         pipe_vld_q, pipe_last_q;
  logic [COLS*DW-1:0]      row_data [ROWS];
  logic [ROWS-1:0]         row_vld, row_last;
  logic                    relu_q;
  logic [4:0]              shift_q;
  logic [ROWS*COLS*OW-1:0] out_data_q, out_data_d;
  logic                    accept, drain_done, capture, release_hold;

  assign in_ready     = (state_q == IDLE) || (state_q == ACCUM);
  assign accept       = in_valid && in_ready;
  // The last-tagged beat leaving the bottom row means every row has seen it.
  assign drain_done   = pipe_vld_q[ROWS-1] && pipe_last_q[ROWS-1];
  assign capture      = (state_q == DRAIN) && drain_done;
  assign out_valid    = (state_q == HOLD);
  assign release_hold = out_valid && out_ready;
  assign busy         = (state_q != IDLE);
  assign out_data     = out_data_q;

  // ReLU, arithmetic shift, then saturate to the signed output range.
  function automatic logic [OW-1:0] quantize(input logic signed [AW-1:0] acc,
                                             input logic relu, input logic [4:0] sh);
    logic signed [AW-1:0] v;
    v = (relu && acc[AW-1]) ? '0 : acc;
    v = v >>> sh;
    if (v > QMAX) v = QMAX;
    else if (v < QMIN) v = QMIN;
    return v[OW-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Window sequencing: accept beats, drain the pipeline, hold the result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row 0 sees the accepted beat directly; deeper rows see the skewed copy.
  always_comb begin
    row_vld  = '0;
    row_last = '0;
    for (int r = 0; r < ROWS; r++) row_data[r] = '0;
    row_data[0] = in_data;
    row_vld[0]  = accept;
    row_last[0] = in_last;
    for (int r = 1; r < ROWS; r++) begin
      row_data[r] = pipe_data_q[r-1];
      row_vld[r]  = pipe_vld_q[r-1];
      row_last[r] = pipe_last_q[r-1];
    end
  end

  // Multiply-accumulate per PE with the row weight broadcast across columns.
  always_comb begin
    logic signed [PW-1:0] data_s, wt_s, prod;
    data_s = '0;
    wt_s   = '0;
    prod   = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        data_s      = signed'(PW'(row_data[r][c*DW +: DW]));
        wt_s        = PW'(w_q[r]);
        prod        = data_s * wt_s;
        acc_d[r][c] = acc_q[r][c];
        if (release_hold)    acc_d[r][c] = '0;
        else if (row_vld[r]) acc_d[r][c] = acc_q[r][c] + AW'(prod);
      end
    end
  end

  // Quantized snapshot of all accumulators once the drain completes.
  always_comb begin
    out_data_d = out_data_q;
    if (capture) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          out_data_d[(r*COLS+c)*OW +: OW] = quantize(acc_q[r][c], relu_q, shift_q);
        end
      end
    end
  end

  // Datapath registers: weights, skew pipeline, accumulators, window settings, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        w_q[r]         <= '0;
        pipe_data_q[r] <= '0;
        for (int c = 0; c < COLS; c++) acc_q[r][c] <= '0;
      end
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      out_data_q  <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (state_q == IDLE && w_load) w_q[r] <= w_data[r*WW +: WW];
        pipe_data_q[r] <= row_data[r];
        for (int c = 0; c < COLS; c++) acc_q[r][c] <= acc_d[r][c];
      end
      pipe_vld_q  <= row_vld;
      pipe_last_q <= row_last & row_vld;
      if (state_q == IDLE && accept) begin
        relu_q  <= relu_en;
        shift_q <= shift_amt;
      end
      out_data_q <= out_data_d;
    end
  end

endmodule
